inv_shift_rows_serial: RTL and testbench
========================================

// Module: inv_shift_rows_serial
// PURPOSE
//  AES InvShiftRows stage for the decryption datapath, column-serial: accepts the
//  4x4 state one column per beat, buffers the full block, then emits the inverse-
//  shifted state one column per beat. Sits between inv round-key add / InvSubBytes
//  stages of the decrypt round; exact inverse of the encrypt ShiftRows mapping.
// PARAMETERS
//  DATA_WIDTH  8  width of one state element (byte)
// PORTS
//  clk        in   1                    rising-edge clock
//  rst_n      in   1                    asynchronous, active-low reset
//  in_valid   in   1                    input column valid
//  in_ready   out  1                    block can accept an input column
//  in_col     in   [DATA_WIDTH-1:0][0:3]  input column; in_col[r] = state[r][c]
//  out_valid  out  1                    output column valid
//  out_ready  in   1                    downstream accepts output column
//  out_col    out  [DATA_WIDTH-1:0][0:3]  output column; out_col[r] = out_state[r][c]
//  out_last   out  1                    high with out_valid on column 3
//  busy       out  1                    high whenever state != FILL or fill count != 0
// BEHAVIOUR
//  - Reset is asynchronous, active-low; clk and rst_n are the only clock/reset.
//  - Reset values: in_ready=1, out_valid=0, out_last=0, busy=0, out_col=0,
//    buffer cleared to 0, state=FILL, in_cnt=0, out_cnt=0.
//  - Mapping: out_state[r][c] = in_state[r][(c - r) mod 4], r,c in 0..3.
//    Row0 unshifted; row1 right-rotate 1; row2 rotate 2; row3 right-rotate 3.
//  - Columns arrive/leave in order c=0,1,2,3; no per-beat column index port.
//  - Handshake: a beat transfers on a cycle where valid && ready are both high.
//    out_valid/out_col held stable until accepted; out_valid never drops without
//    a transfer (except reset). in_valid may toggle freely.
//  - FSM states:
//    FILL : in_ready=1, out_valid=0. On input transfer write in_col into buffer
//           column in_cnt, in_cnt++. Transfer with in_cnt==3 -> DRAIN, in_cnt=0.
//    DRAIN: in_ready=0, out_valid=1, out_col = inverse-shifted column out_cnt,
//           out_last=(out_cnt==3). On output transfer out_cnt++; transfer with
//           out_cnt==3 -> FILL, out_cnt=0.
//  - Latency: input column 3 accepted at edge N -> out_valid=1 with column 0 in
//    the cycle after edge N (registered; no combinational path in_* -> out_*).
//  - Throughput: one block per 8 beats minimum (4 in, 4 out); no overlap, input
//    stalled (in_ready=0) for entire DRAIN.
//  - out_ready held low: block stays in DRAIN indefinitely, output stable.
//  - in_valid during DRAIN is ignored (no write, no counter change).
//  - Counters are 2-bit, wrap 3->0 only via the FSM transitions above.
//  - out_col driven from buffer combinationally via mapping, registered state only;
//    out_col reads 0 when out_valid=0 is NOT required (don't-care), but must be 0
//    after reset until first DRAIN.
//  - Reset mid-block (FILL or DRAIN): partial block discarded, all outputs and
//    counters return to reset values immediately (async), no stale beat emitted.
// TESTING
//  1 Basic: in state[r][c]=8'h{r,c} (cols {00,10,20,30},{01,11,21,31},...) ->
//    out cols {00,13,22,31},{01,10,23,32},{02,11,20,33},{03,12,21,30}, last on 4th.
//  2 Round-trip: encrypt ShiftRows of FIPS-197 state 00112233..eeff fed through
//    block -> output equals original state byte-for-byte.
//  3 Backpressure: out_ready low 5 cycles on column 2 -> out_col stable, in_ready
//    stays 0, then columns 2,3 delivered in order, in_ready=1 next cycle.
//  4 Gapped input: in_valid 1,0,1,0,0,1,1 pattern -> exactly 4 writes, out_valid
//    rises cycle after 4th transfer; in_valid during DRAIN ignored.
//  5 Reset mid-DRAIN after column 1 output -> out_valid=0, in_ready=1, busy=0
//    immediately; next block of all 8'hAA emits four {AA,AA,AA,AA} columns.
//  6 Back-to-back: 3 random blocks with in_valid/out_ready always 1 -> 8-cycle
//    period per block, outputs match reference model.

Source files
------------

// File: rtl/inv_shift_rows_serial_if.sv
// Column-serial handshake bundle for the AES InvShiftRows stage.
// The master side feeds columns and accepts results; the slave side is the stage itself.
interface inv_shift_rows_serial_if #(
  parameter int DATA_WIDTH = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [0:3][DATA_WIDTH-1:0] in_col;
  logic                       out_valid;
  logic                       out_ready;
  logic [0:3][DATA_WIDTH-1:0] out_col;
  logic                       out_last;
  logic                       busy;

  modport master (
    output in_valid, in_col, out_ready,
    input  in_ready, out_valid, out_col, out_last, busy
  );

  modport slave (
    input  in_valid, in_col, out_ready,
    output in_ready, out_valid, out_col, out_last, busy
  );
endinterface

// File: rtl/inv_shift_rows_serial.sv
// AES InvShiftRows, column-serial: buffers four input columns, then emits the
// inverse-shifted block one column per beat (out[r][c] = in[r][(c - r) mod 4]).
module inv_shift_rows_serial #(
  parameter int DATA_WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  inv_shift_rows_serial_if.slave bus
);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                     state_reg;
  logic [1:0]                 in_cnt_reg;
  logic [1:0]                 out_cnt_reg;
  logic                       in_ready_reg;
  logic                       out_valid_reg;
  logic                       out_last_reg;
  logic                       in_fire;
  logic                       out_fire;
  logic [0:3][DATA_WIDTH-1:0] out_col_w;

  assign in_fire  = in_ready_reg & bus.in_valid;
  assign out_fire = out_valid_reg & bus.out_ready;

  // One buffer row per state row; the inverse rotation is just a per-row read offset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      logic [DATA_WIDTH-1:0] row_reg [0:3];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 4; i++) begin
            row_reg[i] <= '0;
          end
        end else if (in_fire) begin
          row_reg[in_cnt_reg] <= bus.in_col[gi];
        end
      end

      assign out_col_w[gi] = row_reg[out_cnt_reg - 2'(gi)];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= FILL;
      in_cnt_reg    <= 2'd0;
      out_cnt_reg   <= 2'd0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (in_fire) begin
            in_cnt_reg <= in_cnt_reg + 2'd1;
            if (in_cnt_reg == 2'd3) begin
              state_reg     <= DRAIN;
              in_cnt_reg    <= 2'd0;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              out_last_reg  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            out_cnt_reg  <= out_cnt_reg + 2'd1;
            out_last_reg <= (out_cnt_reg == 2'd2);
            if (out_cnt_reg == 2'd3) begin
              state_reg     <= FILL;
              out_cnt_reg   <= 2'd0;
              in_ready_reg  <= 1'b1;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

  // Gate the read path so the output stays zero while the buffer is filling.
  assign bus.out_col   = out_valid_reg ? out_col_w : '0;
  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.busy      = (state_reg != FILL) || (in_cnt_reg != 2'd0);

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Directed bench for inv_shift_rows_serial: hand-computed vectors, backpressure,
// gapped input, mid-block reset and back-to-back blocks.
module tb_inv_shift_rows_serial;

  logic clk;
  logic rst_n;
  int   check_cnt;
  int   err_cnt;

  inv_shift_rows_serial_if #(.DATA_WIDTH(8)) bus ();

  inv_shift_rows_serial #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column literal 32'hAABBCCDD means row0=AA, row1=BB, row2=CC, row3=DD.
  logic [31:0] t1_in   [4] = '{32'h00102030, 32'h01112131, 32'h02122232, 32'h03132333};
  logic [31:0] t1_exp  [4] = '{32'h00132231, 32'h01102332, 32'h02112033, 32'h03122130};
  logic [31:0] t2_in   [4] = '{32'h0055aaff, 32'h4499ee33, 32'h88dd2277, 32'hcc1166bb};
  logic [31:0] t2_exp  [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
  logic [31:0] aa_blk  [4] = '{32'haaaaaaaa, 32'haaaaaaaa, 32'haaaaaaaa, 32'haaaaaaaa};
  int          gap_pat [7] = '{1, 0, 1, 0, 0, 1, 1};
  logic [31:0] blk_in  [12];
  logic [31:0] blk_exp [12];
  logic [31:0] tmp_blk [4];
  int          start_cyc [3];
  int          in_idx, out_idx, cyc, j;
  logic        in_x, out_x;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inv_col(input logic [31:0] cols [4], input int c);
    logic [31:0] res;
    logic [31:0] src;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      src = cols[(c - r + 4) % 4];
      res[31-8*r -: 8] = src[31-8*r -: 8];
    end
    return res;
  endfunction

  task automatic send_block(input logic [31:0] cols [4], input string tag);
    for (int i = 0; i < 4; i++) begin
      check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_col   = cols[i];
      tick();
      $display("%s: in col %0d = %h", tag, i, cols[i]);
    end
    bus.in_valid = 1'b0;
    check_eq({tag, "_latency_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic recv_col(input logic [31:0] exp, input int idx, input string tag);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_col"}, bus.out_col, exp);
    check_eq({tag, "_last"}, 32'(bus.out_last), 32'(idx == 3));
    $display("%s: out col %0d = %h last=%0b", tag, idx, bus.out_col, bus.out_last);
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic recv_block(input logic [31:0] exp [4], input string tag);
    for (int i = 0; i < 4; i++) begin
      recv_col(exp[i], i, tag);
    end
    check_eq({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    check_cnt     = 0;
    err_cnt       = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_col    = '0;
    bus.out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_out_col", bus.out_col, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: basic mapping, with out_col held at zero while filling
    bus.in_valid = 1'b1;
    bus.in_col   = t1_in[0];
    tick();
    bus.in_valid = 1'b0;
    check_eq("t1_busy_fill", 32'(bus.busy), 32'd1);
    check_eq("t1_col_zero_fill", bus.out_col, 32'd0);
    check_eq("t1_valid_fill", 32'(bus.out_valid), 32'd0);
    for (int i = 1; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_col   = t1_in[i];
      tick();
    end
    bus.in_valid = 1'b0;
    check_eq("t1_latency_valid", 32'(bus.out_valid), 32'd1);
    recv_block(t1_exp, "t1");

    // 2: FIPS-197 round trip through encrypt ShiftRows
    send_block(t2_in, "t2");
    recv_block(t2_exp, "t2");

    // 3: backpressure on column 2
    send_block(t1_in, "t3");
    recv_col(t1_exp[0], 0, "t3");
    recv_col(t1_exp[1], 1, "t3");
    for (int k = 0; k < 5; k++) begin
      check_eq("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("t3_hold_col", bus.out_col, t1_exp[2]);
      check_eq("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    recv_col(t1_exp[2], 2, "t3");
    recv_col(t1_exp[3], 3, "t3");
    check_eq("t3_in_ready_after", 32'(bus.in_ready), 32'd1);

    // 4: gapped input, then junk presented during DRAIN
    j = 0;
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = gap_pat[k][0];
      bus.in_col   = (gap_pat[k] != 0) ? t2_in[j] : 32'hdeadbeef;
      tick();
      if (gap_pat[k] != 0) j++;
      if (k == 5) check_eq("t4_valid_before_4th", 32'(bus.out_valid), 32'd0);
      if (k == 6) check_eq("t4_valid_after_4th", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b1;
    bus.in_col   = 32'hffffffff;
    for (int k = 0; k < 3; k++) begin
      check_eq("t4_drain_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("t4_drain_busy", 32'(bus.busy), 32'd1);
      check_eq("t4_drain_col", bus.out_col, t2_exp[0]);
      tick();
    end
    bus.in_valid = 1'b0;
    recv_block(t2_exp, "t4");

    // 5: reset in the middle of DRAIN
    send_block(t1_in, "t5");
    recv_col(t1_exp[0], 0, "t5");
    recv_col(t1_exp[1], 1, "t5");
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("t5_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("t5_rst_out_last", 32'(bus.out_last), 32'd0);
    check_eq("t5_rst_out_col", bus.out_col, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("t5_no_stale", 32'(bus.out_valid), 32'd0);
    send_block(aa_blk, "t5aa");
    recv_block(aa_blk, "t5aa");

    // 6: three random blocks back to back
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 4; c++) begin
        blk_in[b*4+c] = $urandom;
        tmp_blk[c]    = blk_in[b*4+c];
      end
      for (int c = 0; c < 4; c++) begin
        blk_exp[b*4+c] = inv_col(tmp_blk, c);
      end
    end
    for (int b = 0; b < 3; b++) start_cyc[b] = -1;
    in_idx = 0;
    out_idx = 0;
    cyc = 0;
    bus.out_ready = 1'b1;
    while (out_idx < 12 && cyc < 80) begin
      if (in_idx < 12) begin
        bus.in_valid = 1'b1;
        bus.in_col   = blk_in[in_idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      in_x  = bus.in_valid && bus.in_ready;
      out_x = bus.out_valid;
      if (out_x) begin
        check_eq("t6_col", bus.out_col, blk_exp[out_idx]);
        check_eq("t6_last", 32'(bus.out_last), 32'((out_idx % 4) == 3));
        $display("t6: out col %0d = %h", out_idx, bus.out_col);
        if ((out_idx % 4) == 0) start_cyc[out_idx/4] = cyc;
      end
      tick();
      cyc++;
      if (in_x) in_idx++;
      if (out_x) out_idx++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("t6_done", 32'(out_idx), 32'd12);
    check_eq("t6_period1", 32'(start_cyc[1] - start_cyc[0]), 32'd8);
    check_eq("t6_period2", 32'(start_cyc[2] - start_cyc[1]), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
